bus_dev_port: RTL and testbench

- Per-device port sitting between a device agent and the bus generator/arbiter (bs_gnrtr_n_rbtr), one instance per device index i.
- TX side buffers agent packets and presents them to the bus on pndng[i]/D_pop[i], draining on pop[i].
- RX side captures bus deliveries from push[i]/D_push[i], filters them by destination ID and buffers them for the device.
- Keeps saturating error counters for verification visibility.

---
 rtl/bus_dev_port.sv | 148 ++++++++++++++
 tb/tb_bus_dev_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dev_port.sv
// bus_dev_port: per-device port between a device agent and the bus
// generator/arbiter. It holds a TX FIFO that the bus drains and an RX FIFO
// that captures bus deliveries addressed to this device. It also keeps
// saturating error counters.
//
// Handshake semantics (all strobes are sampled on the rising clk edge):
//   - pndng / rx_pndng act as "valid". They mean the FIFO head is
//     presented on D_pop / rx_data.
//   - pop / rx_pop act as "ready". When valid is high, a strobe in a cycle
//     consumes the head. When valid is low, the strobe is ignored.
//   - tx_push and push are fire-and-forget writes. They have no
//     backpressure. A write that finds no room is dropped and counted.
//   - A write into a full FIFO is still accepted when a read drains that
//     FIFO in the same cycle.
//   - Valid and head data depend only on registered state. A read strobe
//     therefore never reaches them combinationally.
module bus_dev_port #(
  parameter int          PCKG_SZ  = 24,
  parameter int          DEPTH    = 16,
  parameter logic [7:0]  DEV_ID   = 8'd0,
  parameter logic [7:0]  BCAST_ID = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  // agent -> TX FIFO
  input  logic               tx_push,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  // TX FIFO -> bus
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  // bus -> RX FIFO
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  // RX FIFO -> device
  input  logic               rx_pop,
  output logic               rx_pndng,
  output logic [PCKG_SZ-1:0] rx_data,
  // error counters
  output logic [15:0]        tx_ovf_cnt,
  output logic [15:0]        rx_ovf_cnt,
  output logic [15:0]        misroute_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------- TX side
  logic [PCKG_SZ-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      tx_wp;
  logic [AW-1:0]      tx_rp;
  logic [CW-1:0]      tx_cnt;
  logic               tx_rd;
  logic               tx_wr;
  logic               tx_drop;

  // A read only happens on a non-empty FIFO. A full FIFO makes room for a
  // write when it is read in the same cycle.
  always_comb begin
    tx_rd   = pop && (tx_cnt != '0);
    tx_wr   = tx_push && ((tx_cnt != FULL_CNT) || tx_rd);
    tx_drop = tx_push && !tx_wr;
  end

  // TX storage write. It is not reset, because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && tx_wr) tx_mem[tx_wp] <= tx_data;
  end

  // TX pointers, occupancy and overflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_cnt     <= '0;
      tx_ovf_cnt <= '0;
    end else begin
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_rd) tx_rp <= tx_rp + 1'b1;
      if (tx_wr && !tx_rd)      tx_cnt <= tx_cnt + 1'b1;
      else if (tx_rd && !tx_wr) tx_cnt <= tx_cnt - 1'b1;
      if (tx_drop && (tx_ovf_cnt != CNT_MAX)) tx_ovf_cnt <= tx_ovf_cnt + 16'd1;
    end
  end

  // TX status and head data, taken from registered state only.
  always_comb begin
    pndng   = (tx_cnt != '0);
    tx_full = (tx_cnt == FULL_CNT);
    D_pop   = pndng ? tx_mem[tx_rp] : '0;
  end

  // ---------------------------------------------------------------- RX side
  logic [PCKG_SZ-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      rx_wp;
  logic [AW-1:0]      rx_rp;
  logic [CW-1:0]      rx_cnt;
  logic [7:0]         rx_id;
  logic               rx_match;
  logic               rx_rd;
  logic               rx_wr;
  logic               rx_drop;
  logic               rx_misroute;

  // Destination filter, then the same accept rule as the TX side.
  always_comb begin
    rx_id       = D_push[PCKG_SZ-1:PCKG_SZ-8];
    rx_match    = (rx_id == DEV_ID) || (rx_id == BCAST_ID);
    rx_misroute = push && !rx_match;
    rx_rd       = rx_pop && (rx_cnt != '0);
    rx_wr       = push && rx_match && ((rx_cnt != FULL_CNT) || rx_rd);
    rx_drop     = push && rx_match && !rx_wr;
  end

  // RX storage write. It is not reset, because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && rx_wr) rx_mem[rx_wp] <= D_push;
  end

  // RX pointers, occupancy, overflow and misroute counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_cnt       <= '0;
      rx_ovf_cnt   <= '0;
      misroute_cnt <= '0;
    end else begin
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_rd) rx_rp <= rx_rp + 1'b1;
      if (rx_wr && !rx_rd)      rx_cnt <= rx_cnt + 1'b1;
      else if (rx_rd && !rx_wr) rx_cnt <= rx_cnt - 1'b1;
      if (rx_drop && (rx_ovf_cnt != CNT_MAX)) rx_ovf_cnt <= rx_ovf_cnt + 16'd1;
      if (rx_misroute && (misroute_cnt != CNT_MAX))
        misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

  // RX status and head data, taken from registered state only.
  always_comb begin
    rx_pndng = (rx_cnt != '0);
    rx_data  = rx_pndng ? rx_mem[rx_rp] : '0;
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// tb_bus_dev_port: directed table vectors plus hand-written multi-cycle
// sequences for the bus_dev_port (DEV_ID=3, DEPTH=16).
module tb_bus_dev_port;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_push;
  logic [W-1:0]  tx_data;
  logic          tx_full;
  logic          pndng;
  logic [W-1:0]  d_pop;
  logic          pop;
  logic          push;
  logic [W-1:0]  d_push;
  logic          rx_pop;
  logic          rx_pndng;
  logic [W-1:0]  rx_data;
  logic [15:0]   tx_ovf_cnt;
  logic [15:0]   rx_ovf_cnt;
  logic [15:0]   misroute_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_exp_q[$];

  bus_dev_port #(
    .PCKG_SZ (W),
    .DEPTH   (16),
    .DEV_ID  (8'd3),
    .BCAST_ID(8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_push     (tx_push),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .pndng       (pndng),
    .D_pop       (d_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (d_push),
    .rx_pop      (rx_pop),
    .rx_pndng    (rx_pndng),
    .rx_data     (rx_data),
    .tx_ovf_cnt  (tx_ovf_cnt),
    .rx_ovf_cnt  (rx_ovf_cnt),
    .misroute_cnt(misroute_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         tx_push;
    logic [W-1:0] tx_data;
    logic         pop;
    logic         push;
    logic [W-1:0] d_push;
    logic         rx_pop;
    logic         e_pndng;
    logic [W-1:0] e_d_pop;
    logic         e_full;
    logic         e_rx_pndng;
    logic [W-1:0] e_rx_data;
    logic [15:0]  e_misroute;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge, then settle #1 so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_push = 1'b0; tx_data = '0; pop = 1'b0;
    push = 1'b0; d_push = '0; rx_pop = 1'b0;
  endtask

  task automatic drive(input logic tp, input logic [W-1:0] td, input logic p,
                       input logic ps, input logic [W-1:0] dp, input logic rp);
    tx_push = tp; tx_data = td; pop = p;
    push = ps; d_push = dp; rx_pop = rp;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pndng"},    W'(pndng), '0);
    check({tag, " rx_pndng"}, W'(rx_pndng), '0);
    check({tag, " tx_full"},  W'(tx_full), '0);
    check({tag, " D_pop"},    d_pop, '0);
    check({tag, " rx_data"},  rx_data, '0);
    check({tag, " tx_ovf"},   W'(tx_ovf_cnt), '0);
    check({tag, " rx_ovf"},   W'(rx_ovf_cnt), '0);
    check({tag, " misroute"}, W'(misroute_cnt), '0);
  endtask

  initial begin
    // directed vectors: inputs for one cycle, expected outputs after that edge
    vecs[0]  = '{1'b1, 24'h01AAAA, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h01AAAA, 1'b0, 1'b0, 24'h0, 16'd0};
    vecs[1]  = '{1'b1, 24'h02BBBB, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h01AAAA, 1'b0, 1'b0, 24'h0, 16'd0};
    vecs[2]  = '{1'b1, 24'h03CCCC, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h01AAAA, 1'b0, 1'b0, 24'h0, 16'd0};
    vecs[3]  = '{1'b0, 24'h0,      1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h02BBBB, 1'b0, 1'b0, 24'h0, 16'd0};
    vecs[4]  = '{1'b0, 24'h0,      1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h03CCCC, 1'b0, 1'b0, 24'h0, 16'd0};
    vecs[5]  = '{1'b0, 24'h0,      1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 24'h0, 16'd0};
    vecs[6]  = '{1'b0, 24'h0, 1'b0, 1'b1, 24'h031234, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h031234, 16'd0};
    vecs[7]  = '{1'b0, 24'h0, 1'b0, 1'b1, 24'hFF5678, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h031234, 16'd0};
    vecs[8]  = '{1'b0, 24'h0, 1'b0, 1'b1, 24'h059ABC, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h031234, 16'd1};
    vecs[9]  = '{1'b0, 24'h0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'hFF5678, 16'd1};
    vecs[10] = '{1'b0, 24'h0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0,      16'd1};
    // empty FIFOs, read and write strobes together
    vecs[11] = '{1'b1, 24'h0A0A0A, 1'b1, 1'b1, 24'h030101, 1'b1, 1'b1, 24'h0A0A0A, 1'b0, 1'b1, 24'h030101, 16'd1};
    vecs[12] = '{1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 16'd1};
    // reads on empty FIFOs are ignored
    vecs[13] = '{1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 16'd1};
    vecs[14] = '{1'b1, 24'h111111, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 24'h0, 16'd1};
    vecs[15] = '{1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 16'd1};

    // reset
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].tx_push, vecs[i].tx_data, vecs[i].pop,
            vecs[i].push, vecs[i].d_push, vecs[i].rx_pop);
      tick();
      check($sformatf("v%0d pndng", i),    W'(pndng),        W'(vecs[i].e_pndng));
      check($sformatf("v%0d D_pop", i),    d_pop,            vecs[i].e_d_pop);
      check($sformatf("v%0d tx_full", i),  W'(tx_full),      W'(vecs[i].e_full));
      check($sformatf("v%0d rx_pndng", i), W'(rx_pndng),     W'(vecs[i].e_rx_pndng));
      check($sformatf("v%0d rx_data", i),  rx_data,          vecs[i].e_rx_data);
      check($sformatf("v%0d misroute", i), W'(misroute_cnt), W'(vecs[i].e_misroute));
      check($sformatf("v%0d tx_ovf", i),   W'(tx_ovf_cnt),   '0);
      check($sformatf("v%0d rx_ovf", i),   W'(rx_ovf_cnt),   '0);
    end
    idle_inputs();

    // TX fill to DEPTH; the 17th push is dropped
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 24'h200000 + W'(i), 1'b0, 1'b0, '0, 1'b0);
      if (i < 16) exp_q.push_back(24'h200000 + W'(i));
      tick();
      if (i == 14) check("tx_full before 16th", W'(tx_full), '0);
      if (i == 15) check("tx_full after 16th", W'(tx_full), 24'd1);
    end
    idle_inputs();
    check("tx_full after 17th", W'(tx_full), 24'd1);
    check("tx_ovf after 17th", W'(tx_ovf_cnt), 24'd1);
    check("head after fill", d_pop, exp_q[0]);

    // full TX with push and pop together: accepted, no overflow
    drive(1'b1, 24'h300030, 1'b1, 1'b0, '0, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(24'h300030);
    tick();
    idle_inputs();
    check("full push+pop tx_full", W'(tx_full), 24'd1);
    check("full push+pop tx_ovf", W'(tx_ovf_cnt), 24'd1);
    check("full push+pop head", d_pop, exp_q[0]);

    // drain TX in order; the bound is the expected occupancy
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx drain %0d", i), d_pop, exp_q.pop_front());
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    check("tx drained pndng", W'(pndng), '0);
    check("tx drained D_pop", d_pop, '0);

    // RX fill: broadcast and own ID, the 17th candidate is dropped
    for (int i = 0; i < 17; i++) begin
      logic [W-1:0] pkt;
      pkt = ((i % 2) == 0) ? (24'h034000 + W'(i)) : (24'hFF4000 + W'(i));
      drive(1'b0, '0, 1'b0, 1'b1, pkt, 1'b0);
      if (i < 16) rx_exp_q.push_back(pkt);
      tick();
    end
    // a misrouted packet on a full RX FIFO counts as misroute only
    drive(1'b0, '0, 1'b0, 1'b1, 24'h07EEEE, 1'b0);
    tick();
    idle_inputs();
    check("rx_ovf after 17th", W'(rx_ovf_cnt), 24'd1);
    check("misroute on full", W'(misroute_cnt), 24'd2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rx drain %0d", i), rx_data, rx_exp_q.pop_front());
      rx_pop = 1'b1;
      tick();
    end
    rx_pop = 1'b0;
    check("rx drained rx_pndng", W'(rx_pndng), '0);
    check("rx drained rx_data", rx_data, '0);

    // mid-stream reset with 5 TX and 4 RX entries stored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 24'h500000 + W'(i), 1'b0, (i < 4), 24'h036000 + W'(i), 1'b0);
      tick();
    end
    idle_inputs();
    check("pre-reset pndng", W'(pndng), 24'd1);
    check("pre-reset rx_pndng", W'(rx_pndng), 24'd1);
    reset = 1'b1;
    drive(1'b1, 24'h03ABCD, 1'b1, 1'b1, 24'h03ABCD, 1'b1);
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    idle_inputs();
    tick();
    check_all_zero("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
